alu_src_b_stage: RTL and testbench

//  Parametrised successor of the ALU operand-B source select for the multicycle MIPS datapath.

---
 rtl/alu_src_b_pkg.sv | 20 ++
 rtl/alu_src_b_format.sv | 47 ++++
 rtl/alu_src_b_stage.sv | 105 ++++++++++
 tb/tb_alu_src_b_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_src_b_pkg.sv
// Shared selector encoding for the ALU operand-B source select and FIFO stage.
package alu_src_b_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_REG_B     = 3'd0;
    localparam logic [SEL_W-1:0] SEL_CONST     = 3'd1;
    localparam logic [SEL_W-1:0] SEL_SEXT      = 3'd2;
    localparam logic [SEL_W-1:0] SEL_SEXT_SHL2 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_ZEXT      = 3'd4;
    localparam logic [SEL_W-1:0] SEL_JUMP      = 3'd5;
    localparam logic [SEL_W-1:0] SEL_LUI       = 3'd6;
    localparam logic [SEL_W-1:0] SEL_RSVD      = 3'd7;

    // True for selector codes that have no defined operand format.
    function automatic logic sel_is_rsvd(input logic [SEL_W-1:0] s);
        return (s == SEL_RSVD);
    endfunction

endpackage

// File: rtl/alu_src_b_format.sv
// Combinational operand-B formatter: picks one of seven sources and flags
// reserved selector codes. Kept separate so the jump/branch path can reuse it.
module alu_src_b_format
    import alu_src_b_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int JIMM_W    = 26,
    parameter int INC_CONST = 4
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [WIDTH-1:0]  reg_b,
    input  logic [IMM_W-1:0]  imm,
    input  logic [JIMM_W-1:0] jimm,
    input  logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  operand,
    output logic              rsvd
);

    logic [WIDTH-1:0] sext;
    logic             unused_pc_low;

    assign sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};

    // The jump form only keeps the PC region bits; the low PC bits are dropped.
    assign unused_pc_low = ^pc[JIMM_W+1:0];

    // Source mux; reserved codes produce zero and raise rsvd.
    always_comb begin
        operand = '0;
        rsvd    = 1'b0;
        case (sel)
            SEL_REG_B:     operand = reg_b;
            SEL_CONST:     operand = WIDTH'(INC_CONST);
            SEL_SEXT:      operand = sext;
            SEL_SEXT_SHL2: operand = {sext[WIDTH-3:0], 2'b00};
            SEL_ZEXT:      operand = {{(WIDTH-IMM_W){1'b0}}, imm};
            SEL_JUMP:      operand = {pc[WIDTH-1:JIMM_W+2], jimm, 2'b00};
            SEL_LUI:       operand = {imm, {(WIDTH-IMM_W){1'b0}}};
            default: begin
                operand = '0;
                rsvd    = sel_is_rsvd(sel);
            end
        endcase
    end

endmodule

// File: rtl/alu_src_b_stage.sv
// Operand-B stage: formats the selected source at accept time and queues it
// in a DEPTH-entry FIFO between the control unit and the ALU.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and in_ready is derived from the
// registered occupancy only (a pop from a full FIFO frees space next cycle).
module alu_src_b_stage
    import alu_src_b_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int JIMM_W    = 26,
    parameter int INC_CONST = 4,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           sel,
    input  logic [WIDTH-1:0]           reg_b,
    input  logic [IMM_W-1:0]           imm,
    input  logic [JIMM_W-1:0]          jimm,
    input  logic [WIDTH-1:0]           pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       sel_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] fmt_operand;
    logic             fmt_rsvd;
    logic             push;
    logic             pop;

    // Pointers advance modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    alu_src_b_format #(
        .WIDTH     (WIDTH),
        .IMM_W     (IMM_W),
        .JIMM_W    (JIMM_W),
        .INC_CONST (INC_CONST)
    ) u_format (
        .sel     (sel),
        .reg_b   (reg_b),
        .imm     (imm),
        .jimm    (jimm),
        .pc      (pc),
        .operand (fmt_operand),
        .rsvd    (fmt_rsvd)
    );

    // flush wins over both transfers, so neither side moves during it.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Control state: pointers, occupancy and the reserved-select pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            sel_err <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= push & fmt_rsvd;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is written on accept only; its contents are meaningless when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fmt_operand;
        end
    end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Bench for alu_src_b_stage: vector table, random traffic and directed
// corner sequences, all checked by a FIFO scoreboard sampled on negedge.
module tb_alu_src_b_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] reg_b;
        logic [15:0] imm;
        logic [25:0] jimm;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_sel = '0;
    logic [31:0] reg_b = '0;
    logic [15:0] imm = '0;
    logic [25:0] jimm = '0;
    logic [31:0] pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        sel_err;
    logic [1:0]  count;

    logic [31:0] drv_exp = '0;
    logic [31:0] exp_q[$];
    logic        exp_err = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic        rand_done;
    vec_t        vecs[13];

    alu_src_b_stage #(
        .WIDTH(32), .IMM_W(16), .JIMM_W(26), .INC_CONST(4), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (in_sel),
        .reg_b     (reg_b),
        .imm       (imm),
        .jimm      (jimm),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err),
        .count     (count)
    );

    // Clock and global time bound.
    always #5 clk = ~clk;

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operand formatting.
    function automatic logic [31:0] model(input logic [2:0] s, input logic [31:0] rb,
                                          input logic [15:0] im, input logic [25:0] jm,
                                          input logic [31:0] p);
        logic [31:0] sx;
        sx = {{16{im[15]}}, im};
        case (s)
            3'd0:    return rb;
            3'd1:    return 32'd4;
            3'd2:    return sx;
            3'd3:    return sx << 2;
            3'd4:    return {16'h0000, im};
            3'd5:    return {p[31:28], jm, 2'b00};
            3'd6:    return {im, 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard: checks flags against queue occupancy, pops on transfer out,
    // pushes the driver's expected operand on transfer in.
    always @(negedge clk) begin
        int  sz;
        logic push_now;
        if (!reset) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            sz = exp_q.size();
            check("sel_err", 32'(sel_err), 32'(exp_err));
            check("count", 32'(count), 32'(sz));
            check("in_ready", 32'(in_ready), 32'(sz != DEPTH));
            check("out_valid", 32'(out_valid), 32'(sz != 0));
            if (!out_valid) check("empty_data", out_data, 32'h0);
            if (flush) begin
                exp_q.delete();
                exp_err = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sz == 0) check("pop_underflow", 32'(sz), 32'd1);
                    else check("pop_data", out_data, exp_q.pop_front());
                end
                push_now = in_valid && (sz != DEPTH);
                if (push_now) exp_q.push_back(drv_exp);
                exp_err = push_now && (in_sel == 3'd7);
            end
        end
    end

    // Driver: present one request and hold it until accepted (bounded).
    task automatic push_op(input logic [2:0] s, input logic [31:0] rb, input logic [15:0] im,
                           input logic [25:0] jm, input logic [31:0] p, input logic [31:0] e);
        logic acc;
        acc = 1'b0;
        in_sel = s; reg_b = rb; imm = im; jimm = jm; pc = p; drv_exp = e;
        in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            acc = in_ready && !flush && reset;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset away from the edge and check the asynchronous clear.
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'h0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'hDEADBEEF, 16'h0000, 26'h0,       32'h0,        32'hDEADBEEF};
        vecs[1]  = '{3'd1, 32'h0,        16'h0000, 26'h0,       32'h0,        32'h00000004};
        vecs[2]  = '{3'd2, 32'h0,        16'h8001, 26'h0,       32'h0,        32'hFFFF8001};
        vecs[3]  = '{3'd3, 32'h0,        16'h8001, 26'h0,       32'h0,        32'hFFFE0004};
        vecs[4]  = '{3'd4, 32'h0,        16'h8001, 26'h0,       32'h0,        32'h00008001};
        vecs[5]  = '{3'd6, 32'h0,        16'h8001, 26'h0,       32'h0,        32'h80010000};
        vecs[6]  = '{3'd5, 32'h0,        16'h0000, 26'h0000010, 32'hA0000000, 32'hA0000040};
        vecs[7]  = '{3'd2, 32'h0,        16'h7FFF, 26'h0,       32'h0,        32'h00007FFF};
        vecs[8]  = '{3'd3, 32'h0,        16'h7FFF, 26'h0,       32'h0,        32'h0001FFFC};
        vecs[9]  = '{3'd5, 32'h0,        16'h0000, 26'h3FFFFFF, 32'h5FFFFFFF, 32'h5FFFFFFC};
        vecs[10] = '{3'd6, 32'h0,        16'hFFFF, 26'h0,       32'h0,        32'hFFFF0000};
        vecs[11] = '{3'd7, 32'h12345678, 16'hFFFF, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[12] = '{3'd4, 32'h0,        16'hFFFF, 26'h0,       32'h0,        32'h0000FFFF};

        // T1: reset state, then the increment constant
        apply_reset();
        idle(1);
        out_ready = 1'b1;
        push_op(3'd1, 32'h0, 16'h0, 26'h0, 32'h0, 32'd4);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", out_data, 32'd4);
        idle(2);
        check("t1_count_back", 32'(count), 32'd0);

        // T2/T3: operand formats from the vector table
        for (int i = 0; i < 13; i++) begin
            push_op(vecs[i].sel, vecs[i].reg_b, vecs[i].imm, vecs[i].jimm, vecs[i].pc, vecs[i].exp);
        end
        idle(3);

        // Random traffic with a randomly stalling consumer
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [2:0]  s;
                    logic [31:0] rb;
                    logic [15:0] im;
                    logic [25:0] jm;
                    logic [31:0] p;
                    s  = 3'($urandom_range(0, 7));
                    rb = $urandom;
                    im = 16'($urandom);
                    jm = 26'($urandom);
                    p  = $urandom;
                    push_op(s, rb, im, jm, p, model(s, rb, im, jm, p));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(4);

        // T4: fill, back-pressure, then drain while a third request waits
        out_ready = 1'b0;
        push_op(3'd0, 32'd1, 16'h0, 26'h0, 32'h0, 32'd1);
        push_op(3'd0, 32'd2, 16'h0, 26'h0, 32'h0, 32'd2);
        check("t4_full_in_ready", 32'(in_ready), 32'd0);
        fork
            push_op(3'd0, 32'd3, 16'h0, 26'h0, 32'h0, 32'd3);
            begin
                idle(3);
                out_ready = 1'b1;
                check("t4_full_pop_in_ready", 32'(in_ready), 32'd0);
                idle(1);
                check("t4_in_ready_rise", 32'(in_ready), 32'd1);
            end
        join
        idle(4);

        // T5: reserved selector pulse, then flush of two entries
        out_ready = 1'b0;
        push_op(3'd7, 32'hFFFFFFFF, 16'hFFFF, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h0);
        check("t5_sel_err_hi", 32'(sel_err), 32'd1);
        idle(1);
        check("t5_sel_err_lo", 32'(sel_err), 32'd0);
        push_op(3'd0, 32'd9, 16'h0, 26'h0, 32'h0, 32'd9);
        check("t5_count_two", 32'(count), 32'd2);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("t5_flush_out_valid", 32'(out_valid), 32'd0);
        check("t5_flush_count", 32'(count), 32'd0);
        check("t5_flush_sel_err", 32'(sel_err), 32'd0);
        // a reserved request coinciding with flush is dropped silently
        in_sel = 3'd7; drv_exp = 32'h0; in_valid = 1'b1; flush = 1'b1;
        idle(1);
        in_valid = 1'b0; flush = 1'b0;
        check("t5_flush_push_count", 32'(count), 32'd0);
        check("t5_flush_push_err", 32'(sel_err), 32'd0);
        idle(2);

        // T6: reset with two entries queued, then one-cycle latency after release
        push_op(3'd0, 32'd5, 16'h0, 26'h0, 32'h0, 32'd5);
        push_op(3'd0, 32'd6, 16'h0, 26'h0, 32'h0, 32'd6);
        check("t6_count_two", 32'(count), 32'd2);
        apply_reset();
        out_ready = 1'b1;
        push_op(3'd1, 32'h0, 16'h0, 26'h0, 32'h0, 32'd4);
        check("t6_out_valid", 32'(out_valid), 32'd1);
        check("t6_out_data", out_data, 32'd4);
        idle(4);

        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
